muldiv_alu: RTL and testbench
=============================

Name: muldiv_alu

Overview:
- Parametrised, handshaked successor to the single-cycle ALU of the RISC-V pipeline.
- Executes every base ALU operation (same 4-bit encodings, zero-extended to 5 bits) with one registered cycle of latency.
- Adds RV32M-style multiply/divide/remainder as iterative multi-cycle operations.
- Sits in the EX stage; the hazard unit stalls on ready_o/valid_o.

Parameters:
WIDTH, 32, operand/result width; power of two, >= 8
CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
flush_i  in  1  synchronous abort of any operation, result discarded
valid_i  in  1  operation request
ready_o  out  1  unit can accept a request this cycle
op_i  in  5  operation code
a_i  in  WIDTH  operand A
b_i  in  WIDTH  operand B
valid_o  out  1  result_o/zero_o valid
ready_i  in  1  consumer accepts result
result_o  out  WIDTH  result
zero_o  out  1  result_o == 0

Behaviour:
- Opcodes 0x00-0x0E are the base set: ADD, SUB, LUI (B<<12), OR, SLL, SRL, AND, XOR, BEQ, BNE, BLT, SW (pass A), LW (A+B), JAL (A+4), JALR (A+B).
  - Shifts use b_i[CNT_W-1:0].
  - BEQ/BNE/BLT return 0 when the branch condition holds, 1 otherwise; BLT is signed.
- New opcodes: 0x10 MUL (low WIDTH), 0x11 MULH (signed x signed, high), 0x12 MULHU (unsigned, high), 0x13 DIV (signed), 0x14 DIVU, 0x15 REM (signed), 0x16 REMU.
- Any other code: result 0, one-cycle path.
- FSM states: IDLE, MUL, DIV, DONE.
- Accept: valid_i && ready_o at a rising edge. ready_o = (state==IDLE) || (state==DONE && ready_i), combinational from state. a_i, b_i and op_i are captured at accept and ignored afterwards.
- One-cycle path: on accept, the result is registered and the FSM goes to DONE. valid_o is high in the next cycle (latency 1).
- MUL family:
  - Operands are converted to magnitudes (signed ops only) and run through shift-add, one bit per cycle, WIDTH cycles, into a 2*WIDTH accumulator.
  - The product is negated if the signs differ. Low or high half is selected per op.
  - valid_o rises WIDTH+1 cycles after accept.
- DIV family:
  - Restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles.
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
  - valid_o rises WIDTH+1 cycles after accept.
- Divide by zero: skips iteration and goes straight to DONE (latency 1). Quotient = all ones; remainder = A.
- Signed overflow (A = -2^(WIDTH-1), B = -1): skips iteration (latency 1). Quotient = A; remainder = 0.
- Iteration counter: loads WIDTH-1 on entering MUL/DIV, decrements each cycle. Transition to DONE occurs in the cycle the counter reads 0.
- DONE:
  - result_o and zero_o are held stable while valid_o=1 and ready_i=0.
  - ready_i=1 with valid_i=1 and an op accepted in the same cycle: back-to-back; the next result follows with its normal latency.
  - ready_i=1 with no new request: go to IDLE, valid_o drops.
- zero_o is registered together with result_o, never derived from a changing value.
- flush_i forces IDLE next cycle with valid_o=0, regardless of state. It has priority over accept: a request presented with flush_i is not accepted.
- Reset, including mid-iteration: state IDLE, valid_o=0, result_o=0, zero_o=0, counter=0, accumulators=0. ready_o=1 after reset.
- Busy cycles: valid_i asserted while ready_o=0 is ignored. The requester must hold the request; it is not lost inside the unit.

Test Plan:
- Base ops, WIDTH=32: ADD 5+7 -> result 12, zero 0, valid_o 1 cycle after accept. BEQ 9,9 -> result 0, zero 1. LUI b=0x12345 -> 0x12345000. SLL a=1, b=0x21 -> 2 (shift amount masked to 1).
- MUL a=0xFFFFFFFF, b=2:
  - MUL -> 0xFFFFFFFE; MULH -> 0xFFFFFFFF; MULHU -> 0x00000001.
  - valid_o exactly 33 cycles after accept; ready_o=0 throughout.
- DIV -7/2 -> quotient 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14; REMU -> 2. Each has latency 33.
- Corner cases:
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - All at latency 1.
- Backpressure and throughput:
  - ADD result with ready_i=0 for 4 cycles -> result/valid held stable; a new valid_i is ignored until ready_i.
  - ready_i=1 with a new MUL in the same cycle -> accepted back-to-back.
- Abort:
  - flush_i at cycle 10 of a DIV -> IDLE next cycle, no valid_o pulse; a following ADD completes normally.
  - reset asserted mid-MUL, asynchronously -> valid_o=0, result_o=0 immediately, ready_o=1 after release.

Source files
------------

// File: rtl/muldiv_alu.sv
// muldiv_alu: handshaked EX-stage ALU with iterative RV32M multiply/divide.
// Base ops take one registered cycle; MUL/DIV iterate one bit per cycle.
module muldiv_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [4:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [4:0] OP_MUL   = 5'h10;
    localparam logic [4:0] OP_MULH  = 5'h11;
    localparam logic [4:0] OP_MULHU = 5'h12;
    localparam logic [4:0] OP_DIV   = 5'h13;
    localparam logic [4:0] OP_DIVU  = 5'h14;
    localparam logic [4:0] OP_REM   = 5'h15;
    localparam logic [4:0] OP_REMU  = 5'h16;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [4:0]         op;
    logic               neg;
    // acc: product accumulator, or {remainder, quotient} while dividing
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    // multiplier (shifted right) or divisor magnitude
    logic [WIDTH-1:0]   opnd;

    logic               accept;
    logic               is_mul;
    logic               is_div;
    logic               sgn;
    logic               a_neg;
    logic               b_neg;
    logic               div_zero;
    logic               div_ovf;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   base;
    logic [WIDTH-1:0]   quick;
    logic [WIDTH-1:0]   fin;
    logic [WIDTH-1:0]   dval;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     trial;

    assign ready_o  = (state == IDLE) || (state == DONE && ready_i);
    assign accept   = valid_i && ready_o && !flush_i;
    assign is_mul   = op_i inside {OP_MUL, OP_MULH, OP_MULHU};
    assign is_div   = op_i inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign sgn      = op_i inside {OP_MULH, OP_DIV, OP_REM};
    assign a_neg    = sgn && a_i[WIDTH-1];
    assign b_neg    = sgn && b_i[WIDTH-1];
    assign a_mag    = a_neg ? -a_i : a_i;
    assign b_mag    = b_neg ? -b_i : b_i;
    assign div_zero = (b_i == '0);
    assign div_ovf  = sgn && (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);

    // Single-cycle base ALU, evaluated on the live request operands
    always_comb begin
        base = '0;
        case (op_i)
            5'h00:        base = a_i + b_i;
            5'h01:        base = a_i - b_i;
            5'h02:        base = b_i << 12;
            5'h03:        base = a_i | b_i;
            5'h04:        base = a_i << b_i[CNT_W-1:0];
            5'h05:        base = a_i >> b_i[CNT_W-1:0];
            5'h06:        base = a_i & b_i;
            5'h07:        base = a_i ^ b_i;
            5'h08:        base = {{(WIDTH-1){1'b0}}, a_i != b_i};
            5'h09:        base = {{(WIDTH-1){1'b0}}, a_i == b_i};
            5'h0A:        base = {{(WIDTH-1){1'b0}},
                                  !($signed(a_i) < $signed(b_i))};
            5'h0B:        base = a_i;
            5'h0C, 5'h0E: base = a_i + b_i;
            5'h0D:        base = a_i + WIDTH'(4);
            default:      base = '0;
        endcase
    end

    // Result for the one-cycle path, including divide corner cases
    always_comb begin
        quick = base;
        if (is_div && div_zero) begin
            quick = (op_i == OP_DIV || op_i == OP_DIVU) ? '1 : a_i;
        end else if (is_div && div_ovf) begin
            quick = (op_i == OP_DIV) ? a_i : '0;
        end
    end

    // One shift-add or restoring-divide step on the accumulator
    always_comb begin
        acc_nxt = acc;
        trial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        if (state == MUL) begin
            acc_nxt = opnd[0] ? acc + mcand : acc;
        end else if (state == DIV) begin
            acc_nxt = trial[WIDTH]
                    ? {acc[2*WIDTH-2:0], 1'b0}
                    : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    // Sign fix-up and half selection of the finished iteration
    always_comb begin
        prod = neg ? -acc_nxt : acc_nxt;
        dval = (op == OP_DIV || op == OP_DIVU)
             ? acc_nxt[WIDTH-1:0] : acc_nxt[2*WIDTH-1:WIDTH];
        if (state == MUL) begin
            fin = (op == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        end else begin
            fin = neg ? -dval : dval;
        end
    end

    // Control FSM with registered result, zero flag and valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op       <= '0;
            neg      <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            opnd     <= '0;
            valid_o  <= 1'b0;
            result_o <= '0;
            zero_o   <= 1'b0;
        end else if (flush_i) begin
            state   <= IDLE;
            cnt     <= '0;
            valid_o <= 1'b0;
        end else if (accept) begin
            op    <= op_i;
            neg   <= (op_i == OP_REM) ? a_neg : (a_neg ^ b_neg);
            cnt   <= CNT_W'(WIDTH - 1);
            opnd  <= b_mag;
            mcand <= {{WIDTH{1'b0}}, a_mag};
            if (is_mul) begin
                state   <= MUL;
                valid_o <= 1'b0;
                acc     <= '0;
            end else if (is_div && !div_zero && !div_ovf) begin
                state   <= DIV;
                valid_o <= 1'b0;
                acc     <= {{WIDTH{1'b0}}, a_mag};
            end else begin
                state    <= DONE;
                valid_o  <= 1'b1;
                result_o <= quick;
                zero_o   <= (quick == '0);
            end
        end else if (state == DONE) begin
            if (ready_i) begin
                state   <= IDLE;
                valid_o <= 1'b0;
            end
        end else if (state == MUL || state == DIV) begin
            acc   <= acc_nxt;
            mcand <= mcand << 1;
            cnt   <= cnt - 1'b1;
            if (state == MUL) begin
                opnd <= opnd >> 1;
            end
            if (cnt == '0) begin
                state    <= DONE;
                valid_o  <= 1'b1;
                result_o <= fin;
                zero_o   <= (fin == '0);
            end
        end
    end

endmodule

// File: tb/tb_muldiv_alu.sv
// tb_muldiv_alu: directed and random checks of muldiv_alu against an
// arithmetic reference model (results, zero flag, latency, handshake).
module tb_muldiv_alu;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [4:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        zero_o;

    int compared = 0;
    int mismatched = 0;

    muldiv_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .valid_o(valid_o), .ready_i(ready_i),
        .result_o(result_o), .zero_o(zero_o)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(logic [4:0] op, logic [31:0] a,
                                            logic [31:0] b);
        int          ia;
        int          ib;
        logic [63:0] p;
        logic        ovf;
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            5'h00: return a + b;
            5'h01: return a - b;
            5'h02: return b << 12;
            5'h03: return a | b;
            5'h04: return a << b[4:0];
            5'h05: return a >> b[4:0];
            5'h06: return a & b;
            5'h07: return a ^ b;
            5'h08: return (a == b) ? 32'd0 : 32'd1;
            5'h09: return (a != b) ? 32'd0 : 32'd1;
            5'h0A: return (ia < ib) ? 32'd0 : 32'd1;
            5'h0B: return a;
            5'h0C: return a + b;
            5'h0D: return a + 32'd4;
            5'h0E: return a + b;
            5'h10: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            5'h11: begin p = longint'(ia) * longint'(ib); return p[63:32]; end
            5'h12: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            5'h13: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return 32'(ia / ib);
            end
            5'h14: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'h15: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return 32'(ia % ib);
            end
            5'h16: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(logic [4:0] op, logic [31:0] a,
                                   logic [31:0] b);
        if (op >= 5'h10 && op <= 5'h12) return 33;
        if (op >= 5'h13 && op <= 5'h16) begin
            if (b == 0) return 1;
            if ((op == 5'h13 || op == 5'h15) && a == 32'h8000_0000
                && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        return 1;
    endfunction

    task automatic run_op(string tag, logic [4:0] op, logic [31:0] a,
                          logic [31:0] b);
        int          lat;
        int          busy;
        logic [31:0] exp;
        exp = ref_res(op, a, b);
        @(negedge clk);
        op_i = op; a_i = a; b_i = b; valid_i = 1'b1; ready_i = 1'b0;
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 1;
        busy = 0;
        while (!valid_o && lat < 100) begin
            if (ready_o) busy++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " res"}, result_o, exp);
        check({tag, " zero"}, 32'(zero_o), 32'(exp == 0));
        check({tag, " lat"}, 32'(lat), 32'(ref_lat(op, a, b)));
        check({tag, " busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        check({tag, " drop"}, 32'(valid_o), 32'd0);
    endtask

    logic [4:0] ops [24] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05,
                             5'h06, 5'h07, 5'h08, 5'h09, 5'h0A, 5'h0B,
                             5'h0C, 5'h0D, 5'h0E, 5'h10, 5'h11, 5'h12,
                             5'h13, 5'h14, 5'h15, 5'h16, 5'h0F, 5'h1A};

    initial begin
        int          lat;
        int          seen;
        int          r;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        op_i = '0; a_i = '0; b_i = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset valid", 32'(valid_o), 32'd0);
        check("reset result", result_o, 32'd0);
        check("reset zero", 32'(zero_o), 32'd0);
        check("reset ready", 32'(ready_o), 32'd1);

        run_op("ADD", 5'h00, 32'd5, 32'd7);
        run_op("BEQ", 5'h08, 32'd9, 32'd9);
        run_op("LUI", 5'h02, 32'd0, 32'h12345);
        run_op("SLL", 5'h04, 32'd1, 32'h21);
        run_op("BLT", 5'h0A, 32'hFFFF_FFFE, 32'd1);
        run_op("JAL", 5'h0D, 32'h100, 32'd0);
        run_op("MUL", 5'h10, 32'hFFFF_FFFF, 32'd2);
        run_op("MULH", 5'h11, 32'hFFFF_FFFF, 32'd2);
        run_op("MULHU", 5'h12, 32'hFFFF_FFFF, 32'd2);
        run_op("DIV", 5'h13, 32'hFFFF_FFF9, 32'd2);
        run_op("REM", 5'h15, 32'hFFFF_FFF9, 32'd2);
        run_op("DIVU", 5'h14, 32'd100, 32'd7);
        run_op("REMU", 5'h16, 32'd100, 32'd7);
        run_op("DIV ovf", 5'h13, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("REM ovf", 5'h15, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("DIVU by0", 5'h14, 32'd5, 32'd0);
        run_op("REMU by0", 5'h16, 32'd5, 32'd0);
        run_op("DIV by0", 5'h13, 32'hFFFF_FFF0, 32'd0);
        run_op("bad op", 5'h0F, 32'd3, 32'd4);

        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 7);
            ra = $urandom;
            rb = $urandom;
            if (r == 0) rb = 32'd0;
            if (r == 1) rb = $urandom_range(1, 15);
            if (r == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            run_op("rand", ops[$urandom_range(0, 23)], ra, rb);
        end

        // backpressure: hold the ADD result, queue a MUL behind it
        @(negedge clk);
        op_i = 5'h00; a_i = 32'd3; b_i = 32'd4; valid_i = 1'b1; ready_i = 1'b0;
        @(posedge clk); #1;
        check("bp valid", 32'(valid_o), 32'd1);
        op_i = 5'h10; a_i = 32'd6; b_i = 32'd7;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("bp hold valid", 32'(valid_o), 32'd1);
            check("bp hold res", result_o, 32'd7);
            check("bp hold ready", 32'(ready_o), 32'd0);
        end
        @(negedge clk);
        ready_i = 1'b1;
        #1;
        check("bp ready", 32'(ready_o), 32'd1);
        @(posedge clk); #1;
        valid_i = 1'b0; ready_i = 1'b0;
        check("b2b busy", 32'(valid_o), 32'd0);
        lat = 1;
        while (!valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b res", result_o, 32'd42);
        check("b2b lat", 32'(lat), 32'd33);
        @(negedge clk); ready_i = 1'b1;
        @(posedge clk); #1; ready_i = 1'b0;

        // flush in the middle of a divide
        @(negedge clk);
        op_i = 5'h13; a_i = 32'd1000; b_i = 32'd3; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush_i = 1'b1;
        @(posedge clk); #1; flush_i = 1'b0;
        check("flush valid", 32'(valid_o), 32'd0);
        check("flush ready", 32'(ready_o), 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_o) seen++;
        end
        check("flush no pulse", 32'(seen), 32'd0);

        // flush wins over a simultaneous request
        @(negedge clk);
        op_i = 5'h00; a_i = 32'd1; b_i = 32'd2; valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        check("flush req valid", 32'(valid_o), 32'd0);
        @(posedge clk); #1;
        check("flush req idle", 32'(valid_o), 32'd0);
        run_op("after flush ADD", 5'h00, 32'd1, 32'd1);

        // asynchronous reset in the middle of a multiply
        @(negedge clk);
        op_i = 5'h10; a_i = 32'd123; b_i = 32'd456; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("areset valid", 32'(valid_o), 32'd0);
        check("areset result", result_o, 32'd0);
        check("areset zero", 32'(zero_o), 32'd0);
        @(negedge clk); reset = 1'b0;
        #1;
        check("areset ready", 32'(ready_o), 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_o) seen++;
        end
        check("areset no pulse", 32'(seen), 32'd0);
        run_op("post reset MUL", 5'h10, 32'd123, 32'd456);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
